mult_share_arbiter: RTL
=======================

// Module: mult_share_arbiter
// PURPOSE
//  Shares one iterative multiplier core between NREQ requesters. A round-robin
//  arbiter accepts one operand pair at a time and sequences the core through a
//  start/done handshake. The product is returned to the granted requester over
//  a valid/ready response channel. Sits between client blocks and the
//  shift-add multiplier datapath.
// PARAMETERS
//  NREQ   4   number of requesters (2..8)
//  W      8   operand width; product width is 2*W
//  IDW    2   requester index width, clog2(NREQ)
// PORTS
//  clk         in   1        rising-edge clock
//  rst_n       in   1        asynchronous active-low reset
//  req_valid   in   NREQ     per-requester operand valid
//  req_ready   out  NREQ     one-hot accept strobe
//  req_x       in   NREQ*W   operand x; requester i at [i*W +: W]
//  req_y       in   NREQ*W   operand y; same packing as req_x
//  rsp_valid   out  NREQ     one-hot result valid
//  rsp_ready   in   NREQ     per-requester result accept
//  rsp_data    out  2*W      product; meaningful only while rsp_valid != 0
//  mul_start   out  1        one-cycle start pulse to the core
//  mul_x       out  W        operand x to the core; held from start until done
//  mul_y       out  W        operand y to the core; held from start until done
//  mul_done    in   1        one-cycle completion pulse from the core
//  mul_result  in   2*W      product from the core; valid with mul_done
//  busy        out  1        high in every state except IDLE
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - state=IDLE; all registered outputs go to 0 (req_ready, rsp_valid,
//     rsp_data, mul_start, mul_x, mul_y, busy).
//   - Round-robin pointer last=NREQ-1, so requester 0 has top priority first.
//   - The core shares rst_n. Reset mid-operation abandons the transaction,
//     and no response is produced.
//  FSM states: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
//   IDLE:
//    - If req_valid != 0, grant g = the first valid index after last,
//      searching modulo NREQ.
//    - req_ready[g]=1 for this cycle only (combinational on state and req_valid).
//    - Capture req_x[g], req_y[g] and g, then go to ISSUE.
//   ISSUE:
//    - mul_start=1 for exactly one cycle; mul_x/mul_y driven from the captured
//      operands. Go to WAIT.
//   WAIT:
//    - On mul_done=1, capture mul_result into rsp_data and go to RESP.
//    - No timeout: the controller waits indefinitely.
//   RESP:
//    - rsp_valid[g]=1 and rsp_data stable until rsp_ready[g]=1.
//    - On that handshake: last=g, rsp_valid=0, go to IDLE.
//    - rsp_ready on other indices is ignored.
//  Latency:
//   - Accept at cycle A; mul_start at A+1.
//   - Core done at A+1+L; rsp_valid at A+2+L.
//   - Next accept is no earlier than the cycle after the response handshake.
//  Rules and boundary cases:
//   - At most one transaction is in flight; req_ready stays 0 outside IDLE.
//   - mul_done outside WAIT is ignored.
//   - A requester dropping req_valid before grant is legal. Once granted, its
//     operands are latched and later changes have no effect.
//   - All requesters valid: grants rotate 0,1,2,3,0... with no starvation.
//   - The pointer only advances on a completed response, so a reset
//     mid-operation does not advance it.
//   - Product is full 2*W bits; no truncation. W'hFF*W'hFF = 16'hFE01.
// CONFIGURATION
//  MSA_ZERO_BYPASS_EN
//   - Defined: in IDLE, if the granted x==0 or y==0, skip ISSUE/WAIT. Go
//     straight to RESP with rsp_data=0 and mul_start never pulses; the
//     response appears the cycle after accept.
//   - Undefined: every request goes through the core, including zero operands.
// TESTING
//  1. Reset, then req_valid=4'b0001, x0=8'd12, y0=8'd11 -> req_ready[0]
//     pulses; mul_start one cycle later; rsp_valid[0] with rsp_data=16'd132.
//  2. All four valid together, operands i+1 by i+2, rsp_ready held high ->
//     grant order 0,1,2,3 with products 2,6,12,20; next grant goes back to 0.
//  3. x=8'hFF, y=8'hFF -> rsp_data=16'hFE01; mul_x/mul_y stable from start
//     through done.
//  4. rsp_ready[2]=0 for 5 cycles while req_valid[1]=1 -> rsp_valid[2] and
//     rsp_data held; req_ready[1] stays 0 until the cycle after the handshake.
//  5. Assert rst_n=0 during WAIT -> all outputs 0 at once; after release,
//     requester 0 is granted first; a stray mul_done gives no response.
//  6. x=0, y=8'd7 -> MSA_ZERO_BYPASS_EN defined: no mul_start, rsp_data=0
//     one cycle after accept. Undefined: normal core path, rsp_data=0.

Source files
------------

// File: rtl/mult_share_arbiter.sv
// Round-robin front end that lends one iterative multiplier core to NREQ clients.
// Optional MSA_ZERO_BYPASS_EN: zero operands skip the core and answer with 0 directly.
module mult_share_arbiter #(
    parameter int NREQ = 4,
    parameter int W    = 8,
    parameter int IDW  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*W-1:0] req_x,
    input  logic [NREQ*W-1:0] req_y,
    output logic [NREQ-1:0]   rsp_valid,
    input  logic [NREQ-1:0]   rsp_ready,
    output logic [2*W-1:0]    rsp_data,
    output logic              mul_start,
    output logic [W-1:0]      mul_x,
    output logic [W-1:0]      mul_y,
    input  logic              mul_done,
    input  logic [2*W-1:0]    mul_result,
    output logic              busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [IDW-1:0]   last_q, last_d;
    logic [IDW-1:0]   gnt_q, gnt_d;
    logic [W-1:0]     x_q, x_d;
    logic [W-1:0]     y_q, y_d;
    logic [2*W-1:0]   res_q, res_d;

    logic             found;
    logic [IDW-1:0]   cand;
    logic [IDW-1:0]   gnt_idx;
    logic [W-1:0]     sel_x;
    logic [W-1:0]     sel_y;
    logic [NREQ-1:0]  req_ready_c;

    // Search starts just after the last served requester, wrapping modulo NREQ.
    always_comb begin
        found   = 1'b0;
        cand    = '0;
        gnt_idx = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = IDW'((int'(last_q) + k) % NREQ);
            if (!found && req_valid[cand]) begin
                found   = 1'b1;
                gnt_idx = cand;
            end
        end
    end

    assign sel_x = req_x[int'(gnt_idx)*W +: W];
    assign sel_y = req_y[int'(gnt_idx)*W +: W];

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        gnt_d       = gnt_q;
        x_d         = x_q;
        y_d         = y_q;
        res_d       = res_q;
        req_ready_c = '0;
        rsp_valid   = '0;
        case (state_q)
            S_IDLE: begin
                if (found) begin
                    req_ready_c[gnt_idx] = 1'b1;
                    gnt_d                = gnt_idx;
                    x_d                  = sel_x;
                    y_d                  = sel_y;
`ifdef MSA_ZERO_BYPASS_EN
                    if (sel_x == '0 || sel_y == '0) begin
                        res_d   = '0;
                        state_d = S_RESP;
                    end else begin
                        state_d = S_ISSUE;
                    end
`else
                    state_d = S_ISSUE;
`endif
                end
            end
            S_ISSUE: state_d = S_WAIT;
            S_WAIT: begin
                if (mul_done) begin
                    res_d   = mul_result;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                rsp_valid[gnt_q] = 1'b1;
                // Pointer moves only on a completed response so aborted work keeps its turn.
                if (rsp_ready[gnt_q]) begin
                    last_d  = gnt_q;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            last_q  <= IDW'(NREQ - 1);
            gnt_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            gnt_q   <= gnt_d;
            x_q     <= x_d;
            y_q     <= y_d;
            res_q   <= res_d;
        end
    end

    // Accept strobe is masked during reset so no client sees a phantom grant.
    assign req_ready = rst_n ? req_ready_c : '0;
    assign mul_start = (state_q == S_ISSUE);
    assign mul_x     = x_q;
    assign mul_y     = y_q;
    assign rsp_data  = res_q;
    assign busy      = (state_q != S_IDLE);

endmodule
